// File: rtl/stage_sequencer_if.sv
// Bundle between the game-flow sequencer and its surroundings (inputs, level controller, screen mux).
// STAGE_PAUSE_EN adds the pauseKey/paused pair.
interface stage_sequencer_if;
  logic        startOfFrame;
  logic        oneSecPulse;
  logic        startKey;
  logic        stageEnded;
  logic        stageFailed;
  logic [15:0] money;
  logic        levelEnable;
  logic [1:0]  levelIndex;
  logic [15:0] targetMoney;
  logic        secPulseOut;
  logic [2:0]  screenSel;
`ifdef STAGE_PAUSE_EN
  logic        pauseKey;
  logic        paused;
`endif

  modport master (
    output startOfFrame, oneSecPulse, startKey, stageEnded, stageFailed, money,
`ifdef STAGE_PAUSE_EN
    output pauseKey,
    input  paused,
`endif
    input  levelEnable, levelIndex, targetMoney, secPulseOut, screenSel
  );

  modport slave (
    input  startOfFrame, oneSecPulse, startKey, stageEnded, stageFailed, money,
`ifdef STAGE_PAUSE_EN
    input  pauseKey,
    output paused,
`endif
    output levelEnable, levelIndex, targetMoney, secPulseOut, screenSel
  );
endinterface

// File: rtl/stage_sequencer.sv
// Game-flow FSM: title -> load -> play -> check -> intermission -> next level, ending in game-over or win.
// Optional feature macro STAGE_PAUSE_EN adds a pause toggle active during PLAY.
module stage_sequencer #(
  parameter int NUM_LEVELS  = 3,
  parameter int BASE_TARGET = 650,
  parameter int TARGET_STEP = 400,
  parameter int INTER_SECS  = 5
) (
  input logic              clk,
  input logic              resetN,
  stage_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PLAY, S_CHECK, S_INTER, S_OVER, S_WIN
  } state_t;

  localparam int         CNT_W    = (INTER_SECS < 2) ? 1 : $clog2(INTER_SECS + 1);
  localparam logic [1:0] LAST_LVL = 2'(NUM_LEVELS - 1);

  state_t             state_q, state_d;
  logic [1:0]         lvl_q, lvl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        target;
  logic               paused_q, paused_d;
  logic               ended_g, failed_g;

  // 17-bit sum so a large level target clamps instead of wrapping
  function automatic logic [15:0] sat_target(input logic [1:0] idx);
    logic [16:0] sum;
    sum = 17'(BASE_TARGET) + 17'(idx) * 17'(TARGET_STEP);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  assign target = sat_target(lvl_q);

`ifdef STAGE_PAUSE_EN
  assign ended_g  = bus.stageEnded  & ~paused_q;
  assign failed_g = bus.stageFailed & ~paused_q;
`else
  assign ended_g  = bus.stageEnded;
  assign failed_g = bus.stageFailed;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      lvl_q    <= '0;
      cnt_q    <= '0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      paused_q <= paused_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lvl_d    = lvl_q;
    cnt_d    = cnt_q;
    paused_d = 1'b0;
    case (state_q)
      S_IDLE: if (bus.startKey) begin
        state_d = S_LOAD;
        lvl_d   = '0;
      end
      S_LOAD: if (bus.startOfFrame) state_d = S_PLAY;
      S_PLAY: begin
        if (failed_g)     state_d = S_OVER;
        else if (ended_g) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bus.money >= target) begin
          if (lvl_q >= LAST_LVL) state_d = S_WIN;
          else begin
            state_d = S_INTER;
            cnt_d   = CNT_W'(INTER_SECS);
          end
        end else begin
          state_d = S_OVER;
        end
      end
      // Skip key and final tick in the same cycle still advance only one level
      S_INTER: begin
        if (bus.startKey || (bus.oneSecPulse && cnt_q == CNT_W'(1))) begin
          state_d = S_LOAD;
          if (lvl_q < LAST_LVL) lvl_d = lvl_q + 2'd1;
        end else if (bus.oneSecPulse && cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_OVER, S_WIN: if (bus.startKey) begin
        state_d = S_IDLE;
        lvl_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef STAGE_PAUSE_EN
    paused_d = paused_q;
    if (state_q == S_PLAY && bus.pauseKey) paused_d = ~paused_q;
    if (state_d != S_PLAY) paused_d = 1'b0;
`endif
  end

  always_comb begin
    bus.levelEnable = (state_q == S_PLAY);
    bus.levelIndex  = lvl_q;
    bus.targetMoney = target;
    bus.secPulseOut = (state_q == S_PLAY) && bus.oneSecPulse && !paused_q;
    case (state_q)
      S_IDLE:  bus.screenSel = 3'd0;
      S_INTER: bus.screenSel = 3'd2;
      S_OVER:  bus.screenSel = 3'd3;
      S_WIN:   bus.screenSel = 3'd4;
      default: bus.screenSel = 3'd1;
    endcase
  end

`ifdef STAGE_PAUSE_EN
  assign bus.paused = paused_q;
`endif

endmodule
